// File: rtl/com_uart_pkg.sv
// Shared UART definitions: data-bit configuration encodings and the received-byte width mask.
package com_uart_pkg;

   typedef enum logic [1:0] {
      DBIT_5 = 2'b00,
      DBIT_6 = 2'b01,
      DBIT_7 = 2'b10,
      DBIT_8 = 2'b11
   } dbit_cfg_e;

   // Bits at or above the configured data width are forced to zero.
   function automatic logic [7:0] mask_data(input logic [7:0] data, input logic [1:0] cfg);
      logic [7:0] m;
      case (dbit_cfg_e'(cfg))
         DBIT_5:  m = 8'h1F;
         DBIT_6:  m = 8'h3F;
         DBIT_7:  m = 8'h7F;
         default: m = 8'hFF;
      endcase
      return data & m;
   endfunction

endpackage

// File: rtl/com_sync_edge.sv
// Two-flop synchroniser plus edge-detect flop; emits a registered one-cycle pulse on a rising edge.
// Latency: input rise -> pulse high after 3 clk edges. No backpressure.
module com_sync_edge #(
   parameter logic RESET_VAL = 1'b1
) (
   input  logic clk,
   input  logic rst,
   input  logic async_in,
   output logic rise
);

   logic sync1;
   logic sync2;
   logic sync3;

   // Resetting to the input's idle level keeps the post-reset level from reading as an edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1 <= RESET_VAL;
         sync2 <= RESET_VAL;
         sync3 <= RESET_VAL;
         rise  <= 1'b0;
      end else begin
         sync1 <= async_in;
         sync2 <= sync1;
         sync3 <= sync2;
         rise  <= sync2 & ~sync3;
      end
   end

endmodule

// File: rtl/com_uart_rx_buffer.sv
// UART receive buffer: synchronises frame-complete, masks the byte, queues {parity_err, data} in a FWFT FIFO.
// Latency: rx_write_en rise -> head visible 4 clk edges later; no backpressure, bytes dropped when full (sticky overflow).
module com_uart_rx_buffer
   import com_uart_pkg::*;
#(
   parameter int DEPTH     = 16,
   parameter int THRESHOLD = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [7:0]               rx_data,
   input  logic                     rx_write_en,
   input  logic                     rx_valid_packet,
   input  logic [1:0]               data_bit_config,
   input  logic                     rd_en,
   output logic [7:0]               rd_data,
   output logic                     rd_parity_err,
   output logic                     empty,
   output logic                     full,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     overflow,
   input  logic                     clr_overflow,
   output logic                     rx_irq
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic          push;
   logic          pop_ok;
   logic          push_ok;
   logic          drop;
   logic [CW-1:0] count_nxt;
   logic [PW-1:0] wptr;
   logic [PW-1:0] rptr;
   logic [8:0]    mem [DEPTH];

   com_sync_edge #(
      .RESET_VAL (1'b1)
   ) u_sync_edge (
      .clk      (clk),
      .rst      (rst),
      .async_in (rx_write_en),
      .rise     (push)
   );

   // A push into a full FIFO still lands when the head is popped in the same cycle.
   always_comb begin
      pop_ok    = rd_en && !empty;
      push_ok   = push && (!full || pop_ok);
      drop      = push && full && !pop_ok;
      count_nxt = count;
      if (push_ok && !pop_ok) begin
         count_nxt = count + CW'(1);
      end else if (pop_ok && !push_ok) begin
         count_nxt = count - CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok && !rst) begin
         mem[wptr] <= {~rx_valid_packet, mask_data(rx_data, data_bit_config)};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wptr     <= '0;
         rptr     <= '0;
         count    <= '0;
         empty    <= 1'b1;
         full     <= 1'b0;
         overflow <= 1'b0;
         rx_irq   <= 1'b0;
      end else begin
         if (push_ok) begin
            wptr <= wptr + PW'(1);
         end
         if (pop_ok) begin
            rptr <= rptr + PW'(1);
         end
         count  <= count_nxt;
         empty  <= (count_nxt == '0);
         full   <= (count_nxt == CW'(DEPTH));
         rx_irq <= (count_nxt >= CW'(THRESHOLD));
         if (drop) begin
            overflow <= 1'b1;
         end else if (clr_overflow) begin
            overflow <= 1'b0;
         end
      end
   end

   assign {rd_parity_err, rd_data} = mem[rptr];

endmodule

// File: tb/tb_com_uart_rx_buffer.sv
// Directed bench for com_uart_rx_buffer: reset, latency, masking, overflow, full push+pop, threshold irq.
module tb_com_uart_rx_buffer;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] rx_data;
   logic       rx_write_en;
   logic       rx_valid_packet;
   logic [1:0] data_bit_config;
   logic       rd_en;
   logic [7:0] rd_data;
   logic       rd_parity_err;
   logic       empty;
   logic       full;
   logic [4:0] count;
   logic       overflow;
   logic       clr_overflow;
   logic       rx_irq;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   com_uart_rx_buffer #(
      .DEPTH     (16),
      .THRESHOLD (8)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .rx_data         (rx_data),
      .rx_write_en     (rx_write_en),
      .rx_valid_packet (rx_valid_packet),
      .data_bit_config (data_bit_config),
      .rd_en           (rd_en),
      .rd_data         (rd_data),
      .rd_parity_err   (rd_parity_err),
      .empty           (empty),
      .full            (full),
      .count           (count),
      .overflow        (overflow),
      .clr_overflow    (clr_overflow),
      .rx_irq          (rx_irq)
   );

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Frame completes: level drops for a few clocks then returns high; entry lands 4 edges after the rise.
   task automatic push_byte(input logic [7:0] d, input logic vp);
      rx_data         = d;
      rx_valid_packet = vp;
      rx_write_en     = 1'b0;
      tick(4);
      rx_write_en     = 1'b1;
      tick(4);
   endtask

   task automatic pop_byte(input string tag, input logic [7:0] d, input logic perr);
      check({tag, "_data"}, 32'(rd_data), 32'(d));
      check({tag, "_perr"}, 32'(rd_parity_err), 32'(perr));
      rd_en = 1'b1;
      tick(1);
      rd_en = 1'b0;
   endtask

   initial begin
      rst             = 1'b1;
      rx_data         = 8'h00;
      rx_write_en     = 1'b1;
      rx_valid_packet = 1'b1;
      data_bit_config = 2'b11;
      rd_en           = 1'b0;
      clr_overflow    = 1'b0;
      tick(3);
      rst = 1'b0;
      check("rst_full", 32'(full), 32'd0);
      check("rst_overflow", 32'(overflow), 32'd0);
      check("rst_irq", 32'(rx_irq), 32'd0);
      for (int i = 0; i < 20; i++) begin
         tick(1);
         check("idle_empty", 32'(empty), 32'd1);
         check("idle_count", 32'(count), 32'd0);
      end

      // First byte with explicit latency check.
      rx_data         = 8'hA5;
      rx_valid_packet = 1'b1;
      rx_write_en     = 1'b0;
      tick(4);
      rx_write_en = 1'b1;
      tick(3);
      check("lat3_empty", 32'(empty), 32'd1);
      tick(1);
      check("lat4_empty", 32'(empty), 32'd0);
      check("a5_count", 32'(count), 32'd1);
      pop_byte("a5", 8'hA5, 1'b0);
      check("a5_empty_after_pop", 32'(empty), 32'd1);
      check("a5_count_after_pop", 32'(count), 32'd0);

      data_bit_config = 2'b00;
      push_byte(8'hFF, 1'b0);
      pop_byte("mask5", 8'h1F, 1'b1);
      data_bit_config = 2'b01;
      push_byte(8'hFF, 1'b1);
      pop_byte("mask6", 8'h3F, 1'b0);
      data_bit_config = 2'b10;
      push_byte(8'hFF, 1'b0);
      pop_byte("mask7", 8'h7F, 1'b1);
      data_bit_config = 2'b11;

      // Overflow: 17 pushes into 16 entries.
      for (int i = 0; i < 16; i++) push_byte(8'(i), 1'b1);
      check("fill_full", 32'(full), 32'd1);
      check("fill_count", 32'(count), 32'd16);
      check("fill_no_ovf", 32'(overflow), 32'd0);
      push_byte(8'h10, 1'b1);
      check("ovf_set", 32'(overflow), 32'd1);
      check("ovf_count", 32'(count), 32'd16);
      for (int i = 0; i < 16; i++) pop_byte("ovf_read", 8'(i), 1'b0);
      check("ovf_drain_empty", 32'(empty), 32'd1);
      check("ovf_sticky", 32'(overflow), 32'd1);
      clr_overflow = 1'b1;
      tick(1);
      clr_overflow = 1'b0;
      check("ovf_cleared", 32'(overflow), 32'd0);

      // Full, then push with a simultaneous pop.
      for (int i = 0; i < 16; i++) push_byte(8'h20 + 8'(i), 1'b1);
      check("pp_full", 32'(full), 32'd1);
      rx_data     = 8'h30;
      rx_write_en = 1'b0;
      tick(4);
      rx_write_en = 1'b1;
      tick(3);
      rd_en = 1'b1;
      tick(1);
      rd_en = 1'b0;
      check("pp_count", 32'(count), 32'd16);
      check("pp_no_ovf", 32'(overflow), 32'd0);
      for (int i = 1; i < 16; i++) pop_byte("pp_read", 8'h20 + 8'(i), 1'b0);
      pop_byte("pp_last", 8'h30, 1'b0);
      check("pp_empty", 32'(empty), 32'd1);

      // Threshold interrupt.
      for (int i = 0; i < 7; i++) push_byte(8'h40 + 8'(i), 1'b1);
      check("irq7", 32'(rx_irq), 32'd0);
      push_byte(8'h47, 1'b1);
      check("irq8", 32'(rx_irq), 32'd1);
      pop_byte("irq_pop", 8'h40, 1'b0);
      check("irq_after_pop", 32'(rx_irq), 32'd0);
      check("irq_count", 32'(count), 32'd7);
      pop_byte("pre_rst1", 8'h41, 1'b0);
      pop_byte("pre_rst2", 8'h42, 1'b0);
      check("pre_rst_count", 32'(count), 32'd5);

      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      check("mid_rst_count", 32'(count), 32'd0);
      check("mid_rst_empty", 32'(empty), 32'd1);
      tick(6);
      check("post_rst_count", 32'(count), 32'd0);
      push_byte(8'h5A, 1'b1);
      pop_byte("post_rst_push", 8'h5A, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/com_uart_rx_buffer.md
# com_uart_rx_buffer

Receive-side buffer that sits directly downstream of the UART receiver. It synchronises the receiver's baud-domain frame-complete strobe into the system clock domain and captures each completed byte together with its parity status. Bytes are masked to the configured data width and queued in a first-word-fall-through FIFO. The CPU/peripheral bus drains the FIFO with a pop handshake and sees level, overflow and threshold-interrupt status.

## Interface
- `DEPTH`, 16: FIFO entries; power of two, minimum 2.
- `THRESHOLD`, 8: `rx_irq` asserts when `count >= THRESHOLD`; range 1..DEPTH.
- `clk` in 1: system clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `rx_data` in 8: receiver byte buffer; baud domain, quasi-static while `rx_write_en` is high.
- `rx_write_en` in 1: receiver frame-complete level; baud domain; high while the receiver is idle.
- `rx_valid_packet` in 1: receiver parity-OK flag; baud domain.
- `data_bit_config` in 2: data width, 00=5 … 11=8 bits; quasi-static.
- `rd_en` in 1: pop the head entry; ignored when `empty`.
- `rd_data` out 8: head byte, valid while `!empty`.
- `rd_parity_err` out 1: head entry parity error (inverse of captured `rx_valid_packet`).
- `empty` out 1: FIFO holds no entries.
- `full` out 1: FIFO holds DEPTH entries.
- `count` out $clog2(DEPTH)+1: current occupancy.
- `overflow` out 1: sticky flag set when a byte is dropped.
- `clr_overflow` in 1: clears `overflow`.
- `rx_irq` out 1: level interrupt, `count >= THRESHOLD`.

## Operation
- Capture path:
  - 2-flop synchroniser on `rx_write_en`, plus a third flop for edge detect.
  - All three flops reset to 1, so the receiver's post-reset idle level never creates a push.
  - A push request is generated on a synchronised rising edge (0→1).
- On a push request, the block samples `rx_data` and `rx_valid_packet` directly. Both are stable for the whole receiver idle period.
- Width mask: bits at or above `5+data_bit_config` are forced to 0.
- FIFO storage is a DEPTH×9 array ({parity_err, data}), with binary write and read pointers that wrap modulo DEPTH, plus an occupancy counter.
- Push and pop rules:
  - Push when not full: write at wptr, increment wptr.
  - Push when full with no pop in the same cycle: byte dropped, `overflow` set to 1.
  - Push when full with a pop in the same cycle: push accepted, `count` unchanged.
  - Pop when not empty: increment rptr.
  - Pop when empty: no effect.
  - Push and pop in the same cycle: both take effect, `count` unchanged.
- `overflow`: if `clr_overflow` and a dropped push occur in the same cycle, set wins.
- Reset values:
  - `empty`=1, `full`=0, `count`=0, `overflow`=0, `rx_irq`=0.
  - `rd_data` and `rd_parity_err` are don't-care while empty.
  - Pointers=0.
- Reset mid-operation discards all queued entries. A frame completing during reset is lost.

## Timing
- `clk` must be at least 8× the baud tick rate, so the edge is detected well within one baud period.
- Push latency: `rx_write_en` rises → entry visible (`empty` low, `rd_data` valid) 4 `clk` edges later: 2 sync, 1 edge detect, 1 write.
- FWFT read:
  - `rd_data` and `rd_parity_err` reflect the head combinationally from the registered array and rptr.
  - After a pop, the next entry appears the following cycle.
- `empty`, `full`, `count`, `rx_irq` and `overflow` are all registered and update on the edge that performs the push or pop.
- At most one push per baud period. No back-pressure to the receiver.

## Structure
- Shared package `com_uart_pkg`: data-bit config encodings (`DBIT_5`…`DBIT_8`) and the width-mask function.
- One natural sub-module, `com_sync_edge`: a parameterised 2-flop synchroniser with rising-edge pulse output and configurable reset level, reused for other baud-domain strobes.
- FIFO array, pointers and flags stay inline.

## Test plan
- Reset with `rx_write_en`=1 held → no push; `empty`=1, `count`=0 for 20 cycles.
- Toggle `rx_write_en` 1→0→1 with `rx_data`=8'hA5, `rx_valid_packet`=1, config 11 → after 4 clocks `rd_data`=8'hA5, `rd_parity_err`=0, `count`=1. Then `rd_en` → `empty`=1.
- Config 00, `rx_data`=8'hFF, `rx_valid_packet`=0 → `rd_data`=8'h1F, `rd_parity_err`=1.
- DEPTH=16: push 17 bytes 0x00..0x10 with no reads → `full`=1, `overflow`=1. Reads return 0x00..0x0F in order, then `empty`=1. Then `clr_overflow` → `overflow`=0.
- Fill to full, then push and `rd_en` in the same cycle → `count` stays 16, `overflow` stays 0, the new byte is read last.
- THRESHOLD=8: push 7 → `rx_irq`=0; 8th push → `rx_irq`=1; one pop → `rx_irq`=0. Assert `rst` with 5 queued → `count`=0 next cycle.
